// File: rtl/icache_dm.sv
// Direct-mapped one-word-line instruction cache: 1-cycle hit, byte-serial refill on miss (out_valid at C6 with continuous grant).
// Output holds while out_valid & !out_ready; req_ready_out drops during refill or stalled output; rdy_in=0 freezes everything.
module icache_dm #(
  parameter int ICACHE_LINES = 64,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  req_valid_in,
  input  logic [ADDR_WIDTH-1:0] req_pc_in,
  output logic                  req_ready_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc_out,
  output logic                  mem_req_out,
  input  logic                  mem_gnt_in,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  input  logic [7:0]            mem_din
);
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESP} state_t;

  state_t                  r_state;
  logic [ICACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [31:0]             r_data [ICACHE_LINES];
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [23:0]             r_buf;
  logic [2:0]              r_issue_cnt;
  logic [2:0]              r_recv_cnt;
  logic                    r_pending;
  logic                    r_rdy_q;

  logic [ADDR_WIDTH-1:0]   w_req_pc;
  logic [IDX_W-1:0]        w_req_idx;
  logic [TAG_W-1:0]        w_req_tag;
  logic [IDX_W-1:0]        w_fill_idx;
  logic [TAG_W-1:0]        w_fill_tag;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_lost;
  logic                    w_got;
  logic                    w_issue;
  logic                    w_fill;
  logic [31:0]             w_word;

  assign w_req_pc   = req_pc_in & ~ADDR_WIDTH'(3);
  assign w_req_idx  = w_req_pc[2+IDX_W-1:2];
  assign w_req_tag  = w_req_pc[ADDR_WIDTH-1:2+IDX_W];
  assign w_fill_idx = r_pc[2+IDX_W-1:2];
  assign w_fill_tag = r_pc[ADDR_WIDTH-1:2+IDX_W];
  assign w_hit      = r_valid[w_req_idx] & (r_tag[w_req_idx] == w_req_tag);

  assign req_ready_out = (r_state == S_IDLE) & (~out_valid | out_ready);
  assign w_accept      = rdy_in & ~flush_in & req_valid_in & req_ready_out;

  // A byte that returned during a frozen cycle was dropped: rewind issue to it.
  assign w_lost = r_pending & ~r_rdy_q;
  assign w_got  = r_pending & r_rdy_q;

  assign mem_req_out = rdy_in & ~flush_in & (r_state == S_FETCH) & ~r_issue_cnt[2] & ~w_lost;
  assign mem_a_out   = {r_pc[ADDR_WIDTH-1:2], r_issue_cnt[1:0]};
  assign w_issue     = mem_req_out & mem_gnt_in;

  assign w_word = {mem_din, r_buf};
  assign w_fill = rdy_in & ~flush_in & (r_state == S_FETCH) & w_got & (r_recv_cnt == 3'd3);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_pc         <= '0;
      r_buf        <= '0;
      r_issue_cnt  <= '0;
      r_recv_cnt   <= '0;
      r_pending    <= 1'b0;
      r_rdy_q      <= 1'b1;
      out_valid    <= 1'b0;
      instr_out    <= '0;
      instr_pc_out <= '0;
    end else if (!rdy_in) begin
      r_rdy_q <= 1'b0;
    end else begin
      r_rdy_q <= 1'b1;
      if (flush_in) begin
        r_state     <= S_IDLE;
        out_valid   <= 1'b0;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_pending   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              if (w_hit) begin
                out_valid    <= 1'b1;
                instr_out    <= r_data[w_req_idx];
                instr_pc_out <= w_req_pc;
              end else begin
                out_valid   <= 1'b0;
                r_pc        <= w_req_pc;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
                r_pending   <= 1'b0;
                r_state     <= S_FETCH;
              end
            end else if (out_ready) begin
              out_valid <= 1'b0;
            end
          end
          S_FETCH: begin
            r_pending <= w_issue;
            if (w_lost) begin
              r_issue_cnt <= r_recv_cnt;
            end else if (w_issue) begin
              r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if (w_got) begin
              case (r_recv_cnt[1:0])
                2'd0:    r_buf[7:0]   <= mem_din;
                2'd1:    r_buf[15:8]  <= mem_din;
                2'd2:    r_buf[23:16] <= mem_din;
                default: ;
              endcase
              r_recv_cnt <= r_recv_cnt + 3'd1;
            end
            if (w_fill) begin
              r_valid[w_fill_idx] <= 1'b1;
              out_valid           <= 1'b1;
              instr_out           <= w_word;
              instr_pc_out        <= r_pc;
              r_state             <= S_RESP;
            end
          end
          S_RESP: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= w_word;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a byte memory model answers refills, expected words are queued at request time.
module tb_icache_dm;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        req_valid_in;
  logic [31:0] req_pc_in;
  logic        req_ready_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        mem_req_out;
  logic        mem_gnt_in;
  logic [31:0] mem_a_out;
  logic [7:0]  mem_din;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_ins[$];
  int          iss_cyc[$];
  logic [31:0] iss_addr[$];
  bit          rnd_gnt = 1'b0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] last_ins;
  logic [31:0] last_pc;
  int          last_c0;
  int          last_k0;

  icache_dm #(.ICACHE_LINES(64), .ADDR_WIDTH(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .req_valid_in(req_valid_in), .req_pc_in(req_pc_in), .req_ready_out(req_ready_out),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out), .mem_req_out(mem_req_out), .mem_gnt_in(mem_gnt_in),
    .mem_a_out(mem_a_out), .mem_din(mem_din)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (a[31:2] == 30'h400) begin
      case (a[1:0])
        2'd0:    return 8'h13;
        2'd1:    return 8'h05;
        2'd2:    return 8'h10;
        default: return 8'h00;
      endcase
    end
    return a[7:0] ^ {a[13:8], 2'b00} ^ 8'h5A;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    logic [31:0] b;
    b = pc & ~32'd3;
    return {mb(b + 32'd3), mb(b + 32'd2), mb(b + 32'd1), mb(b)};
  endfunction

  // Memory: data appears the cycle after a granted issue, garbage otherwise.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (mem_req_out && mem_gnt_in) begin
      mem_din <= mb(mem_a_out);
      iss_cyc.push_back(cyc);
      iss_addr.push_back(mem_a_out);
    end else begin
      mem_din <= 8'hEE;
    end
  end

  task automatic tick();
    logic        x;
    logic [31:0] i, p, ei, ep;
    x = out_valid & out_ready & rdy_in;
    i = instr_out;
    p = instr_pc_out;
    @(posedge clk_in);
    #1;
    if (x) begin
      checks++;
      if (sb_pc.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", p, i);
      end else begin
        ep = sb_pc.pop_front();
        ei = sb_ins.pop_front();
        if (p !== ep || i !== ei) begin
          errors++;
          $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h", p, i, ep, ei);
        end
      end
      last_ins = i;
      last_pc  = p;
    end
    if (rnd_gnt) mem_gnt_in = 1'($urandom_range(0, 1));
    if (rnd_rdy) rdy_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_req(input logic [31:0] pc, input int exp_lat, input int exp_iss, input string nm);
    int n;
    n = 0;
    while (!req_ready_out && n < 200) begin tick(); n++; end
    checks++;
    if (req_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: req_ready_out=%b, required 1", nm, req_ready_out);
    end
    rdy_in       = 1'b1;
    req_valid_in = 1'b1;
    req_pc_in    = pc;
    last_c0      = cyc;
    last_k0      = iss_cyc.size();
    sb_pc.push_back(pc & ~32'd3);
    sb_ins.push_back(word_of(pc));
    tick();
    req_valid_in = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", nm, n, exp_lat);
    end
    checks++;
    if (iss_cyc.size() - last_k0 != exp_iss) begin
      errors++;
      $display("FAIL %s_issues: got %0d byte reads, required %0d", nm, iss_cyc.size() - last_k0, exp_iss);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; req_valid_in = 1'b0;
    req_pc_in = '0; out_ready = 1'b1; mem_gnt_in = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || mem_req_out !== 1'b0 || req_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b mem_req_out=%b req_ready_out=%b, required 0 0 1",
               out_valid, mem_req_out, req_ready_out);
    end
    checks++;
    if (instr_out !== 32'h0 || instr_pc_out !== 32'h0 || mem_a_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: instr=%h pc=%h addr=%h, required all zero", instr_out, instr_pc_out, mem_a_out);
    end
    #9 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    do_req(32'h0, 6, 4, "t1_miss0");
  endtask

  task automatic test_cold_miss();
    do_req(32'h1000, 6, 4, "t2_cold");
    checks++;
    if (iss_cyc.size() < last_k0 + 4) begin
      errors++;
      $display("FAIL t2_issue_log: got %0d reads, required 4", iss_cyc.size() - last_k0);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (iss_addr[last_k0+j] !== 32'h1000 + 32'(j) || iss_cyc[last_k0+j] != last_c0 + 1 + j) begin
          errors++;
          $display("FAIL t2_issue%0d: got addr=%h at C%0d, required addr=%h at C%0d", j,
                   iss_addr[last_k0+j], iss_cyc[last_k0+j] - last_c0, 32'h1000 + 32'(j), j + 1);
        end
      end
    end
    checks++;
    if (last_ins !== 32'h00100513 || last_pc !== 32'h1000) begin
      errors++;
      $display("FAIL t2_word: got instr=%h pc=%h, required instr=00100513 pc=00001000", last_ins, last_pc);
    end
  endtask

  task automatic test_hit();
    do_req(32'h1000, 1, 0, "t3_hit");
    checks++;
    if (last_ins !== 32'h00100513) begin
      errors++;
      $display("FAIL t3_word: got %h, required 00100513", last_ins);
    end
  endtask

  task automatic test_conflict();
    do_req(32'h1100, 6, 4, "t4_evict");
    do_req(32'h1000, 6, 4, "t4_remiss");
  endtask

  task automatic test_flush();
    int n;
    n = 0;
    while (!req_ready_out && n < 200) begin tick(); n++; end
    req_valid_in = 1'b1;
    req_pc_in    = 32'h2010;
    tick();
    req_valid_in = 1'b0;
    repeat (3) tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mem_req_out !== 1'b0 || req_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL t5_after_flush: out_valid=%b mem_req_out=%b req_ready_out=%b, required 0 0 1",
               out_valid, mem_req_out, req_ready_out);
    end
    repeat (6) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || mem_req_out !== 1'b0) begin
        errors++;
        $display("FAIL t5_quiet: out_valid=%b mem_req_out=%b, required 0 0", out_valid, mem_req_out);
      end
    end
    flush_in = 1'b1; req_valid_in = 1'b1; req_pc_in = 32'h1000;
    tick();
    flush_in = 1'b0; req_valid_in = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mem_req_out !== 1'b0 || req_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL t5_req_in_flush: out_valid=%b mem_req_out=%b req_ready_out=%b, required 0 0 1",
               out_valid, mem_req_out, req_ready_out);
    end
    do_req(32'h2010, 6, 4, "t5_refetch");
  endtask

  task automatic test_backpressure();
    logic [31:0] hi, hp;
    int n;
    out_ready = 1'b0;
    rnd_gnt = 1'b1;
    rnd_rdy = 1'b1;
    rdy_in = 1'b1; req_valid_in = 1'b1; req_pc_in = 32'h3008;
    sb_pc.push_back(32'h3008);
    sb_ins.push_back(word_of(32'h3008));
    tick();
    req_valid_in = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin tick(); n++; end
    hi = instr_out;
    hp = instr_pc_out;
    checks++;
    if (out_valid !== 1'b1 || hi !== word_of(32'h3008) || hp !== 32'h3008) begin
      errors++;
      $display("FAIL t6_refill: valid=%b instr=%h pc=%h, required 1 %h 00003008", out_valid, hi, hp, word_of(32'h3008));
    end
    repeat (3) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || instr_out !== hi || instr_pc_out !== hp || req_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL t6_hold: valid=%b instr=%h pc=%h ready=%b, required 1 %h %h 0",
                 out_valid, instr_out, instr_pc_out, req_ready_out, hi, hp);
      end
    end
    rnd_gnt = 1'b0; rnd_rdy = 1'b0; rdy_in = 1'b1; mem_gnt_in = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    req_valid_in = 1'b1; req_pc_in = 32'h3008;
    sb_pc.push_back(32'h3008);
    sb_ins.push_back(word_of(32'h3008));
    tick();
    req_valid_in = 1'b0;
    repeat (2) begin
      checks++;
      if (out_valid !== 1'b1 || instr_out !== word_of(32'h3008) || req_ready_out !== 1'b0) begin
        errors++;
        $display("FAIL t6_hit_hold: valid=%b instr=%h ready=%b, required 1 %h 0",
                 out_valid, instr_out, req_ready_out, word_of(32'h3008));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    pcs[0] = 32'h1000; pcs[1] = 32'h3009; pcs[2] = 32'h2010; pcs[3] = 32'h1002;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (req_ready_out !== 1'b1 || mem_req_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stream%0d: ready=%b mem_req_out=%b, required 1 0", j, req_ready_out, mem_req_out);
      end
      req_valid_in = 1'b1;
      req_pc_in    = pcs[j];
      sb_pc.push_back(pcs[j] & ~32'd3);
      sb_ins.push_back(word_of(pcs[j]));
      tick();
    end
    req_valid_in = 1'b0;
    tick();
    tick();
    checks++;
    if (sb_pc.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d outputs outstanding, required 0", sb_pc.size());
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
